// File: rtl/pipe_adder_pkg.sv
// Shared constants, types and elaboration helpers for the chunked pipelined adder.
package pipe_adder_pkg;

    localparam int unsigned DefaultWidth = 32;
    localparam int unsigned DefaultChunk = 8;

    typedef enum logic {
        OpAdd = 1'b0,
        OpSub = 1'b1
    } op_e;

    // Per-stage control record; data fields are sized in the module itself.
    typedef struct packed {
        logic valid;
    } stage_ctrl_t;

    function automatic bit chunk_cfg_ok(input int unsigned width, input int unsigned chunk);
        return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

    // Clamped to 1 so arrays stay legal while the configuration error is reported.
    function automatic int unsigned calc_stages(input int unsigned width,
                                                input int unsigned chunk);
        if (chunk == 0 || width < chunk) begin
            return 1;
        end
        return width / chunk;
    endfunction

endpackage

// File: rtl/adder_chunk_stage.sv
// One CHUNK-bit registered slice adder: {cout, sum} <= a + b + cin when enabled.
module adder_chunk_stage #(
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] add_d;
    logic [CHUNK:0] add_q;

    always_comb begin
        add_d = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_q <= '0;
        end else if (en) begin
            add_q <= add_d;
        end
    end

    assign sum  = add_q[CHUNK-1:0];
    assign cout = add_q[CHUNK];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK slice per stage, carry registered between
// stages, valid/ready on both sides with a single global advance enable.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned CHUNK = DefaultChunk
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int unsigned STAGES   = calc_stages(WIDTH, CHUNK);
    localparam int unsigned ResDepth = (STAGES > 1) ? STAGES - 1 : 1;

    if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
        $error("pipe_adder: WIDTH must be a positive integer multiple of CHUNK");
    end

    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Operand preparation: subtraction is A + ~B + 1, carry-in ignored.
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    always_comb begin
        b_eff = in_b;
        c0    = in_cin;
        unique case (op_e'(in_sub))
            OpAdd: begin
                b_eff = in_b;
                c0    = in_cin;
            end
            OpSub: begin
                b_eff = ~in_b;
                c0    = 1'b1;
            end
            default: begin
                b_eff = in_b;
                c0    = in_cin;
            end
        endcase
    end

    // Per-stage operands feeding each slice adder.
    logic [WIDTH-1:0] a_in    [STAGES];
    logic [WIDTH-1:0] b_in    [STAGES];
    logic             c_in    [STAGES];
    logic             v_in    [STAGES];
    // Completed sum slices below stage k (upper bits always zero).
    logic [WIDTH-1:0] sum_lo  [STAGES];
    // sum_lo plus this stage's freshly registered slice.
    logic [WIDTH-1:0] sum_asm [STAGES];
    logic [CHUNK-1:0] chunk_sum [STAGES];
    logic             c_out   [STAGES];
    stage_ctrl_t      ctrl_q  [STAGES];
    // Operands travelling skewed alongside the partial result.
    logic [WIDTH-1:0] a_res_q [ResDepth];
    logic [WIDTH-1:0] b_res_q [ResDepth];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign a_in[k]   = in_a;
            assign b_in[k]   = b_eff;
            assign c_in[k]   = c0;
            assign v_in[k]   = in_valid;
            assign sum_lo[k] = '0;
        end else begin : g_body
            assign a_in[k] = a_res_q[k-1];
            assign b_in[k] = b_res_q[k-1];
            assign c_in[k] = c_out[k-1];
            assign v_in[k] = ctrl_q[k-1].valid;

            logic [WIDTH-1:0] sum_lo_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum_lo_q <= '0;
                end else if (adv) begin
                    sum_lo_q <= sum_asm[k-1];
                end
            end

            assign sum_lo[k] = sum_lo_q;
        end

        adder_chunk_stage #(
            .CHUNK(CHUNK)
        ) u_chunk (
            .clk  (clk),
            .rst  (rst),
            .en   (adv),
            .a    (a_in[k][k*CHUNK +: CHUNK]),
            .b    (b_in[k][k*CHUNK +: CHUNK]),
            .cin  (c_in[k]),
            .sum  (chunk_sum[k]),
            .cout (c_out[k])
        );

        assign sum_asm[k] = sum_lo[k] | (WIDTH'(chunk_sum[k]) << (k * CHUNK));

        // Valid bits shift with the data so bubbles are held, never squeezed.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ctrl_q[k] <= '0;
            end else if (adv) begin
                ctrl_q[k].valid <= v_in[k];
            end
        end

        if (k < STAGES - 1) begin : g_res
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_res_q[k] <= '0;
                    b_res_q[k] <= '0;
                end else if (adv) begin
                    a_res_q[k] <= a_in[k];
                    b_res_q[k] <= b_in[k];
                end
            end
        end
    end

    if (STAGES == 1) begin : g_no_res
        assign a_res_q[0] = '0;
        assign b_res_q[0] = '0;
    end

    // Operand MSB parity of the top slice; with the sum MSB it yields the carry into the MSB.
    logic msb_xor_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msb_xor_q <= 1'b0;
        end else if (adv) begin
            msb_xor_q <= a_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1];
        end
    end

    logic c_into_msb;

    assign out_valid  = ctrl_q[STAGES-1].valid;
    assign out_sum    = sum_asm[STAGES-1];
    assign out_cout   = c_out[STAGES-1];
    assign c_into_msb = msb_xor_q ^ out_sum[WIDTH-1];
    assign out_ovf    = c_into_msb ^ out_cout;

endmodule

// File: tb/tb_pipe_adder.sv
// Directed table-driven bench for pipe_adder (WIDTH=32, CHUNK=8) with a scoreboard monitor.
module tb_pipe_adder;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned CHUNK  = 8;
    localparam int          STAGES = 4;
    localparam int          NVEC   = 14;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    pipe_adder #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    vec_t vecs [NVEC];
    vec_t exp_q [$];
    int   acc_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   cur_idx  = 0;
    int   rx_cnt   = 0;
    bit   lat_chk  = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
    endtask

    // Scoreboard: record accepted beats, compare every emitted result in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    note_fail("unexpected_out");
                end else begin
                    vec_t e;
                    int   t;
                    e = exp_q.pop_front();
                    t = acc_q.pop_front();
                    check("sum", 64'(out_sum), 64'(e.sum));
                    check("cout", 64'(out_cout), 64'(e.cout));
                    check("ovf", 64'(out_ovf), 64'(e.ovf));
                    if (lat_chk) check("latency", 64'(cyc - t), 64'(STAGES));
                    rx_cnt++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(vecs[cur_idx]);
                acc_q.push_back(cyc);
            end
        end
    end

    task automatic send(input int idx);
        bit acc;
        int k;
        cur_idx  = idx;
        in_a     = vecs[idx].a;
        in_b     = vecs[idx].b;
        in_cin   = vecs[idx].cin;
        in_sub   = vecs[idx].sub;
        in_valid = 1'b1;
        acc      = 1'b0;
        k        = 0;
        while (!acc && k < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            k++;
        end
        if (!acc) note_fail("accept_timeout");
    endtask

    task automatic drain();
        int k;
        in_valid = 1'b0;
        k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (exp_q.size() != 0) note_fail("drain_timeout");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           a              b             cin   sub   sum           cout  ovf
        vecs[0]  = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[2]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[3]  = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[4]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[5]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[6]  = '{32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0};
        vecs[7]  = '{32'h00FF00FF, 32'h00010001, 1'b1, 1'b0, 32'h01000101, 1'b0, 1'b0};
        vecs[8]  = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[9]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1};
        vecs[10] = '{32'h00001234, 32'h00001234, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[12] = '{32'h00000010, 32'h00000003, 1'b0, 1'b1, 32'h0000000D, 1'b1, 1'b0};
        vecs[13] = '{32'hA0B0C0D0, 32'h5F4F3F30, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;

        #2;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_sum", 64'(out_sum), 64'(0));
        check("rst_out_cout", 64'(out_cout), 64'(0));
        check("rst_out_ovf", 64'(out_ovf), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Back-to-back stream of every table vector at full throughput.
        for (int i = 0; i < NVEC; i++) send(i);
        drain();

        // Backpressure: stall the output for three cycles mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++) send(i);
                in_valid = 1'b0;
            end
            begin
                int k;
                lat_chk = 1'b0;
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!out_valid && k < 50);
                if (!out_valid) note_fail("stall_wait_timeout");
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", 64'(in_ready), 64'(0));
                    check("stall_out_valid", 64'(out_valid), 64'(1));
                    if (exp_q.size() > 0) begin
                        check("stall_sum", 64'(out_sum), 64'(exp_q[0].sum));
                        check("stall_cout", 64'(out_cout), 64'(exp_q[0].cout));
                        check("stall_ovf", 64'(out_ovf), 64'(exp_q[0].ovf));
                    end else begin
                        note_fail("stall_queue_empty");
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        lat_chk = 1'b1;

        // Reset mid-flight: three beats in, first one emerges, then async reset.
        for (int i = 0; i < 3; i++) send(i);
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_out_sum", 64'(out_sum), 64'(0));
        check("midrst_out_cout", 64'(out_cout), 64'(0));
        check("midrst_out_ovf", 64'(out_ovf), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("post_rst_idle", 64'(out_valid), 64'(0));
        end
        @(posedge clk);
        #1;
        send(13);
        drain();

        check("out_count", 64'(rx_cnt), 64'(NVEC + 8 + 1 + 1));
        check("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined two's-complement adder/subtractor; successor to the fixed-width 8/16/32-bit adder tree.
- Operands split into CHUNK-bit slices, one slice added per pipeline stage, with the carry registered between stages. Achieves full WIDTH at one result per clock.
- Valid/ready handshake on both sides, so it drops into streaming datapaths with backpressure.
- Adds carry-in, carry-out, subtract mode and signed-overflow flag, which the combinational adders lack.

Parameters:
- WIDTH, 32, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 8, bits added per pipeline stage.
- STAGES, WIDTH/CHUNK, derived (localparam); pipeline depth = latency in cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in (add mode only).
- in_sub  in  1  1 = compute A - B; 0 = A + B + cin.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  WIDTH  result, modulo 2^WIDTH.
- out_cout  out  1  carry out of MSB (add) / NOT borrow (sub).
- out_ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - All stage valid bits and data/carry registers clear to 0.
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0.
  - in_ready=1 from the first cycle after reset.
- Advance enable: adv = !out_valid || out_ready; in_ready = adv (combinational).
  - When adv=1, every stage shifts forward one position; stage 0 loads the input beat, or a bubble if in_valid=0.
  - When adv=0, all stages hold, including bubbles. Bubbles are not squeezed.
- Beat accepted on cycle t (in_valid && in_ready): result presented with out_valid=1 at cycle t+STAGES if adv stays 1.
  - Each adv=0 cycle delays it by one cycle.
  - Throughput: 1 beat/clk when out_ready is held at 1.
- Operand prep at stage 0:
  - b_eff = in_sub ? ~in_b : in_b.
  - c0 = in_sub ? 1 : in_cin; in_cin is ignored when in_sub=1.
- Stage k (0..STAGES-1):
  - Computes {c_k+1, s_k} = a[k*CHUNK +: CHUNK] + b_eff[same] + c_k, a (CHUNK+1)-bit add.
  - Upper operand slices travel skewed alongside the data; completed lower sum slices are carried forward.
  - Final stage also records the carry into the MSB: bit CHUNK-1 of the top slice, recomputed internally.
- out_cout = c_STAGES. out_ovf = c_into_msb XOR c_STAGES. Both are defined for add and sub.
- Output held stable while out_valid && !out_ready (AXI-style no-retract rule).
- Wrap: results are modulo 2^WIDTH; no saturation.
- Reset mid-operation: all in-flight beats are discarded, none emitted after reset.
- STAGES=1 (CHUNK=WIDTH): degenerates to a single registered adder with latency 1; must be supported.
- Elaboration error if WIDTH % CHUNK != 0 or CHUNK < 1.

Decomposition:
- Package pipe_adder_pkg: default WIDTH/CHUNK constants; function computing STAGES; a stage-record typedef (valid, carry, partial sum, residual a/b) parametrised via localparams in the module.
- Sub-module adder_chunk_stage: one CHUNK-wide registered slice adder with carry in/out, enable and async reset. Instantiated STAGES times in a generate loop.

Test Plan (WIDTH=32, CHUNK=8, STAGES=4):
- Single add, out_ready=1: a=0x000000FF, b=0x00000001, cin=0, accepted cycle 0 -> cycle 4: out_sum=0x00000100, cout=0, ovf=0; carry ripples across stage boundary.
- Full carry chain: a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, ovf=0. Then a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, cout=0, ovf=1.
- Subtract: a=5, b=7, sub=1, cin=1 -> sum=0xFFFFFFFE, cout=0 (borrow); a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, ovf=1, cout=1.
- Back-to-back 16 beats with random operands, out_ready=1 -> 16 results on consecutive cycles in order, first at cycle 4, matching the reference model.
- Backpressure: stream 8 beats; drop out_ready for 3 cycles while out_valid=1 -> in_ready=0 those cycles, out_sum/flags stable, no loss or duplication, order preserved.
- Reset mid-flight: 3 beats in pipeline, assert rst asynchronously mid-cycle -> out_valid=0 and outputs 0 immediately; no stale result after release; next beat has latency 4.
